// File: rtl/gba_line_cache_if.sv
`default_nettype none
// ============================================================================
// gba_line_cache_if
// Capture-side write stream and imageGen read bus of the GBA line cache.
// Revision: 1.0
// ============================================================================
interface gba_line_cache_if;
  logic        wrValid;
  logic [4:0]  wrRed;
  logic [4:0]  wrGreen;
  logic [4:0]  wrBlue;
  logic        wrVsync;
  logic [7:0]  curPxl;
  logic        nextLine;
  logic        cacheUpdate;
  logic [71:0] rowTop;
  logic [71:0] rowMid;
  logic [71:0] rowBot;
  logic        sameLine;
  logic        newFrame;
  logic        overrun;

  modport master (
    output wrValid, wrRed, wrGreen, wrBlue, wrVsync, curPxl, nextLine, cacheUpdate,
    input  rowTop, rowMid, rowBot, sameLine, newFrame, overrun
  );

  modport slave (
    input  wrValid, wrRed, wrGreen, wrBlue, wrVsync, curPxl, nextLine, cacheUpdate,
    output rowTop, rowMid, rowBot, sameLine, newFrame, overrun
  );
endinterface
`default_nettype wire

// File: rtl/gba_line_cache.sv
`default_nettype none
// ============================================================================
// gba_line_cache
// Ring of GBA line buffers: stores captured lines, serves 3x3 neighbourhoods.
// Revision: 1.0
// ============================================================================
module gba_line_cache #(
  parameter int LINE_PIXELS = 240,
  parameter int FRAME_LINES = 160,
  parameter int NUM_BUFS    = 4
) (
  input  logic            pxlClk,
  input  logic            rst,
  gba_line_cache_if.slave bus
);
  localparam int              BW        = $clog2(NUM_BUFS);
  localparam int              FW        = $clog2(NUM_BUFS + 1);
  localparam logic [BW-1:0]   LAST_BUF  = BW'(NUM_BUFS - 1);
  localparam logic [7:0]      LAST_PXL  = 8'(LINE_PIXELS - 1);
  localparam logic [7:0]      LAST_LINE = 8'(FRAME_LINES - 1);
  localparam logic [7:0]      NUM_LINES = 8'(FRAME_LINES);
  localparam logic [FW-1:0]   FULL_FILL = FW'(NUM_BUFS - 1);

  function automatic logic [BW-1:0] buf_inc(input logic [BW-1:0] b);
    return (b == LAST_BUF) ? '0 : b + BW'(1);
  endfunction

  function automatic logic [BW-1:0] buf_dec(input logic [BW-1:0] b);
    return (b == '0) ? LAST_BUF : b - BW'(1);
  endfunction

  function automatic logic [23:0] expand(input logic [14:0] p);
    return {p[14:10], p[14:12], p[9:5], p[9:7], p[4:0], p[4:2]};
  endfunction

  logic [14:0] line_mem [NUM_BUFS][LINE_PIXELS];

  logic [7:0]    wr_pxl_q, wr_pxl_d;
  logic [BW-1:0] wr_buf_q, wr_buf_d;
  logic [7:0]    wr_y_q, wr_y_d;
  logic [BW-1:0] rd_buf_q, rd_buf_d;
  logic [7:0]    rd_y_q, rd_y_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [BW-1:0] disp_buf_q, disp_buf_d;
  logic [7:0]    disp_y_q, disp_y_d;
  logic          new_frame_q, new_frame_d;
  logic          overrun_q, overrun_d;
  logic [71:0]   row_top_q, row_top_d;
  logic [71:0]   row_mid_q, row_mid_d;
  logic [71:0]   row_bot_q, row_bot_d;

  logic          wr_accept;
  logic          line_done;
  logic [FW-1:0] need;
  logic          same_line;
  logic          nl_accept;
  logic          lap;
  logic [7:0]    col, col_prev, col_next;
  logic [BW-1:0] buf_top, buf_bot;

  always_comb begin
    wr_accept = bus.wrValid && !bus.wrVsync && (wr_y_q < NUM_LINES);
    line_done = wr_accept && (wr_pxl_q == LAST_PXL);
    // The last line has no successor, so one complete line is enough there.
    need      = (rd_y_q < LAST_LINE) ? FW'(2) : FW'(1);
    same_line = (fill_q < need);
    nl_accept = bus.nextLine && !same_line && (rd_y_q < LAST_LINE) && !bus.wrVsync;
    lap       = line_done && (fill_q == FULL_FILL);

    wr_pxl_d    = wr_pxl_q;
    wr_buf_d    = wr_buf_q;
    wr_y_d      = wr_y_q;
    rd_buf_d    = rd_buf_q;
    rd_y_d      = rd_y_q;
    fill_d      = fill_q;
    overrun_d   = overrun_q;
    new_frame_d = line_done && (wr_y_q == '0);

    if (bus.wrVsync) begin
      wr_pxl_d  = '0;
      wr_buf_d  = '0;
      wr_y_d    = '0;
      rd_buf_d  = '0;
      rd_y_d    = '0;
      fill_d    = '0;
      overrun_d = 1'b0;
    end else begin
      if (wr_accept) begin
        wr_pxl_d = line_done ? '0 : wr_pxl_q + 8'd1;
      end
      if (line_done) begin
        wr_buf_d = buf_inc(wr_buf_q);
        wr_y_d   = wr_y_q + 8'd1;
      end
      // A lap drags the reader forward one line; a same-cycle nextLine folds into it.
      if (lap) begin
        overrun_d = 1'b1;
        rd_buf_d  = buf_inc(rd_buf_q);
        rd_y_d    = rd_y_q + 8'd1;
      end else if (nl_accept) begin
        rd_buf_d = buf_inc(rd_buf_q);
        rd_y_d   = rd_y_q + 8'd1;
        fill_d   = line_done ? fill_q : fill_q - FW'(1);
      end else if (line_done) begin
        fill_d = fill_q + FW'(1);
      end
    end

    disp_buf_d = disp_buf_q;
    disp_y_d   = disp_y_q;
    if (bus.wrVsync) begin
      disp_buf_d = '0;
      disp_y_d   = '0;
    end else if (bus.cacheUpdate) begin
      disp_buf_d = rd_buf_d;
      disp_y_d   = rd_y_d;
    end
  end

  always_comb begin
    col      = (bus.curPxl > LAST_PXL) ? LAST_PXL : bus.curPxl;
    col_prev = (col == '0) ? col : col - 8'd1;
    col_next = (col == LAST_PXL) ? col : col + 8'd1;
    buf_top  = (disp_y_q == '0) ? disp_buf_q : buf_dec(disp_buf_q);
    buf_bot  = (disp_y_q == LAST_LINE) ? disp_buf_q : buf_inc(disp_buf_q);

    row_top_d = {expand(line_mem[buf_top][col_prev]),
                 expand(line_mem[buf_top][col]),
                 expand(line_mem[buf_top][col_next])};
    row_mid_d = {expand(line_mem[disp_buf_q][col_prev]),
                 expand(line_mem[disp_buf_q][col]),
                 expand(line_mem[disp_buf_q][col_next])};
    row_bot_d = {expand(line_mem[buf_bot][col_prev]),
                 expand(line_mem[buf_bot][col]),
                 expand(line_mem[buf_bot][col_next])};
  end

  always_ff @(posedge pxlClk) begin
    if (wr_accept) begin
      line_mem[wr_buf_q][wr_pxl_q] <= {bus.wrRed, bus.wrGreen, bus.wrBlue};
    end
  end

  always_ff @(posedge pxlClk) begin
    if (rst) begin
      wr_pxl_q    <= '0;
      wr_buf_q    <= '0;
      wr_y_q      <= '0;
      rd_buf_q    <= '0;
      rd_y_q      <= '0;
      fill_q      <= '0;
      disp_buf_q  <= '0;
      disp_y_q    <= '0;
      new_frame_q <= 1'b0;
      overrun_q   <= 1'b0;
      row_top_q   <= '0;
      row_mid_q   <= '0;
      row_bot_q   <= '0;
    end else begin
      wr_pxl_q    <= wr_pxl_d;
      wr_buf_q    <= wr_buf_d;
      wr_y_q      <= wr_y_d;
      rd_buf_q    <= rd_buf_d;
      rd_y_q      <= rd_y_d;
      fill_q      <= fill_d;
      disp_buf_q  <= disp_buf_d;
      disp_y_q    <= disp_y_d;
      new_frame_q <= new_frame_d;
      overrun_q   <= overrun_d;
      row_top_q   <= row_top_d;
      row_mid_q   <= row_mid_d;
      row_bot_q   <= row_bot_d;
    end
  end

  assign bus.rowTop   = row_top_q;
  assign bus.rowMid   = row_mid_q;
  assign bus.rowBot   = row_bot_q;
  assign bus.sameLine = same_line;
  assign bus.newFrame = new_frame_q;
  assign bus.overrun  = overrun_q;
endmodule
`default_nettype wire
